mc_controlunit: RTL
===================

Name: mc_controlunit

Overview:
- Multi-cycle successor to the single-cycle MIPS control unit; one instruction spans 3–5 cycles over a shared memory/ALU datapath.
- Moore FSM driving datapath enables and muxes, with an optional memory-ready stall handshake.
- Adds a retired-instruction counter and an illegal-opcode pulse.
- Sits between the instruction register (opcode source), the ALU controller (consumes ALUOp) and the PC/register-file/memory enables.

Parameters:
- OP_W, 6: opcode width; opcode values are zero-extended constants (R-type 0x00, ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02).
- CNT_W, 32: width of the retired-instruction counter.
- WAIT_EN, 1: 1 = honour mem_ready; 0 = mem_ready treated as constant 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  OP_W  opcode field from the instruction register; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut.
- MemRead / MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  load instruction register.
- RegDst  out  1  1 = rd, 0 = rt.
- MemToReg  out  1  1 = memory data, 0 = ALUOut.
- RegWrite  out  1  register-file write enable.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- ALUOp  out  2  00 = funct-decoded, 01 = add, 10 = subtract.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- PCEn  out  1  PC load enable.
- instr_done  out  1  one-cycle pulse per retired instruction.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst low, asynchronous):
  - state = FETCH, op_q = 0, instr_count = 0.
  - Every output is forced to 0 while rst is low, including FETCH strobes.
- Outputs are decoded from state only, except PCEn, IRWrite and the FETCH-state PCWrite, which are gated by rdy.
  - rdy = mem_ready | ~WAIT_EN.
  - Any output not listed for a state is 0.
- opcode is latched into op_q in DECODE. Later states use op_q, so IR changes after DECODE have no effect.
- States, outputs and transitions:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=01, PCSrc=00; IRWrite=rdy, PCEn=rdy. rdy -> DECODE, else stay.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=01 (branch target).
    - LW/SW -> MEMADR; R-type -> EXEC; BEQ -> BRANCH; ADDI -> ADDIEX; J -> JUMP.
    - Any other opcode: illegal=1 for that cycle -> FETCH, not counted.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=01. op_q==LW -> MEMRD, else -> MEMWR.
  - MEMRD: IorD=1, MemRead=1. rdy -> MEMWB, else stay.
  - MEMWB: RegDst=0, MemToReg=1, RegWrite=1 -> FETCH, retire.
  - MEMWR: IorD=1, MemWrite=1. rdy -> FETCH with retire; else stay, with MemWrite held.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=00 -> ALUWB.
  - ALUWB: RegDst=1, MemToReg=0, RegWrite=1 -> FETCH, retire.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=01 -> ADDIWB.
  - ADDIWB: RegDst=0, MemToReg=0, RegWrite=1 -> FETCH, retire.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=10, PCSrc=01, PCEn=zero -> FETCH, retire.
  - JUMP: PCSrc=10, PCEn=1 -> FETCH, retire.
- Retire:
  - instr_done=1 combinationally in the retiring cycle.
  - instr_count increments on that edge and wraps modulo 2^CNT_W, with no saturation.
- Latency with rdy=1 throughout: J/BEQ 3 cycles; R-type/ADDI/SW 4; LW 5. Each stall cycle adds 1.
- Reset mid-instruction abandons the instruction: no retire, count cleared, restart in FETCH after rst release.
- Encoding: one-hot or binary (implementer's choice); no unreachable-state lockup, and any illegal encoding goes to FETCH.

Test Plan:
- Reset release, mem_ready=1, opcode=0x00: states FETCH, DECODE, EXEC, ALUWB, FETCH. RegWrite=1 and RegDst=1 only in cycle 4; instr_done pulses once; instr_count=1.
- LW (0x23) with mem_ready low for 2 cycles in FETCH and 3 in MEMRD: 10 cycles total. IRWrite/PCEn high only on the ready FETCH cycle. MemToReg=1 and RegWrite=1 in MEMWB; count +1.
- BEQ (0x04), zero=1 then zero=0 on two runs: PCEn=1, PCSrc=01 in BRANCH on the first, PCEn=0 on the second. Both retire after 3 cycles.
- Opcode 0x3F: illegal=1 in DECODE, back to FETCH next cycle, instr_done=0, count unchanged. opcode changed to 0x23 during MEMADR of an SW still yields MEMWR (op_q latched).
- CNT_W=4: 16 J instructions (3 cycles each) -> instr_count wraps 15 -> 0. WAIT_EN=0 with mem_ready tied 0 still fetches with no stall.
- rst driven low during MEMWR with mem_ready=0: all outputs 0 immediately (asynchronous). After release: FETCH, instr_count=0, no instr_done pulse.

Source files
------------

// File: rtl/mc_controlunit.sv
// Multi-cycle MIPS control unit: Moore FSM driving datapath enables and muxes,
// with memory-ready stalls, a retired-instruction counter and an illegal pulse.
module mc_controlunit #(
    parameter int OP_W    = 6,
    parameter int CNT_W   = 32,
    parameter bit WAIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2B);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h02);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP
    } state_t;

    state_t          state, nxt;
    logic [OP_W-1:0] op_q;
    logic            rdy;

    assign rdy = mem_ready | (WAIT_EN == 1'b0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            op_q        <= '0;
            instr_count <= '0;
        end else begin
            state <= nxt;
            if (state == DECODE)
                op_q <= opcode;
            if (instr_done)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        nxt        = state;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemToReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        PCEn       = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        unique case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b01;
                IRWrite = rdy;
                PCEn    = rdy;
                if (rdy)
                    nxt = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = 2'b01;
                // decode uses the live opcode; op_q is loaded on this edge
                unique case (1'b1)
                    (opcode == OP_LW) || (opcode == OP_SW): nxt = MEMADR;
                    opcode == OP_R:    nxt = EXEC;
                    opcode == OP_BEQ:  nxt = BRANCH;
                    opcode == OP_ADDI: nxt = ADDIEX;
                    opcode == OP_J:    nxt = JUMP;
                    default: begin
                        illegal = 1'b1;
                        nxt     = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b01;
                nxt     = (op_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (rdy)
                    nxt = MEMWB;
            end
            MEMWB: begin
                MemToReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (rdy) begin
                    instr_done = 1'b1;
                    nxt        = FETCH;
                end
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                nxt     = ALUWB;
            end
            ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b01;
                nxt     = ADDIWB;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                PCSrc      = 2'b01;
                PCEn       = zero;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            JUMP: begin
                PCSrc      = 2'b10;
                PCEn       = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            default: nxt = FETCH;
        endcase
        // FETCH strobes must not leak out while reset is held
        if (!rst) begin
            IorD       = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegDst     = 1'b0;
            MemToReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ALUOp      = 2'b00;
            PCSrc      = 2'b00;
            PCEn       = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule
